// File: rtl/ram_transfer_engine_if.sv
// rtl/ram_transfer_engine_if.sv - sequencer handshake and dual RAM port bundle for ram_transfer_engine
`timescale 1ns/1ps
interface ram_transfer_engine_if #(
  parameter int WORD_W = 128
);
  // sequencer handshake
  logic              command_transfer;
  logic              read_write_command;
  logic [5:0]        read_address;
  logic [5:0]        write_address;
  logic [9:0]        Data_len_Polynomial;
  logic              interupt_transfer;
  logic              busy;
  // outer operand RAM port
  logic [5:0]        outer_addr;
  logic              outer_rd_en;
  logic              outer_wr_en;
  logic [WORD_W-1:0] outer_wdata;
  logic [WORD_W-1:0] outer_rdata;
  // inner ECC working bank port
  logic [5:0]        inner_addr;
  logic              inner_rd_en;
  logic              inner_wr_en;
  logic [WORD_W-1:0] inner_wdata;
  logic [WORD_W-1:0] inner_rdata;

  // environment side: sequencer plus both RAMs
  modport master (
    output command_transfer, read_write_command, read_address, write_address,
           Data_len_Polynomial, outer_rdata, inner_rdata,
    input  interupt_transfer, busy,
           outer_addr, outer_rd_en, outer_wr_en, outer_wdata,
           inner_addr, inner_rd_en, inner_wr_en, inner_wdata
  );

  // engine side
  modport slave (
    input  command_transfer, read_write_command, read_address, write_address,
           Data_len_Polynomial, outer_rdata, inner_rdata,
    output interupt_transfer, busy,
           outer_addr, outer_rd_en, outer_wr_en, outer_wdata,
           inner_addr, inner_rd_en, inner_wr_en, inner_wdata
  );
endinterface

// File: rtl/ram_transfer_engine.sv
// rtl/ram_transfer_engine.sv - operand copy engine between outer RAM and inner ECC bank; optional TRANSFER_ZERO_FILL_EN
`timescale 1ns/1ps
module ram_transfer_engine #(
  parameter int WORD_W    = 128,
  parameter int MAX_WORDS = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  ram_transfer_engine_if.slave   bus
);

  localparam int NW_W = $clog2(MAX_WORDS + 1);
  localparam int WT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WT   = 3'd2,
    S_WR   = 3'd3,
    S_FILL = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            cmd_q, cmd_d;
  logic            dir_q, dir_d;
  logic [5:0]      src_q, src_d;
  logic [5:0]      dst_q, dst_d;
  logic [NW_W-1:0] nwords_q, nwords_d;
  logic [NW_W-1:0] idx_q, idx_d;
  logic [WT_W-1:0] wait_q, wait_d;

  logic            start;
  logic            last_word;
  logic            last_fill;
  logic            fill_go;
  logic [31:0]     ceil_words;
  logic [NW_W-1:0] nwords_calc;
  logic [5:0]      outer_src_addr, outer_dst_addr;
  logic [5:0]      inner_src_addr, inner_dst_addr;

  assign start     = bus.command_transfer & ~cmd_q & (state_q == S_IDLE);
  assign last_word = (idx_q == (nwords_q - NW_W'(1)));
  assign last_fill = (idx_q == NW_W'(MAX_WORDS - 1));

`ifdef TRANSFER_ZERO_FILL_EN
  // only outer->inner copies clear the stale upper words of the bank
  assign fill_go = ~dir_q & (nwords_q < NW_W'(MAX_WORDS));
`else
  assign fill_go = 1'b0;
`endif

  // outer addresses wrap over the whole RAM, inner offsets wrap inside the bank
  assign outer_src_addr = src_q + 6'(idx_q);
  assign outer_dst_addr = dst_q + 6'(idx_q);
  assign inner_src_addr = {src_q[5:3], src_q[2:0] + 3'(idx_q)};
  assign inner_dst_addr = {dst_q[5:3], dst_q[2:0] + 3'(idx_q)};

  // word count from field degree: ceil(m / WORD_W), clamped to 1..MAX_WORDS
  always_comb begin
    ceil_words = (32'(bus.Data_len_Polynomial) + 32'(WORD_W - 1)) / 32'(WORD_W);
    if (ceil_words == 32'd0)
      nwords_calc = NW_W'(1);
    else if (ceil_words > 32'(MAX_WORDS))
      nwords_calc = NW_W'(MAX_WORDS);
    else
      nwords_calc = NW_W'(ceil_words);
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cmd_q    <= 1'b0;
      dir_q    <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      nwords_q <= '0;
      idx_q    <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      dir_q    <= dir_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      nwords_q <= nwords_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
    end
  end

  // request latch, word index and read-latency wait counter
  always_comb begin
    cmd_d    = bus.command_transfer;
    dir_d    = dir_q;
    src_d    = src_q;
    dst_d    = dst_q;
    nwords_d = nwords_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    if (start) begin
      dir_d    = bus.read_write_command;
      src_d    = bus.read_address;
      dst_d    = bus.write_address;
      nwords_d = nwords_calc;
      idx_d    = '0;
    end
    case (state_q)
      S_RD:   wait_d = '0;
      S_WT:   wait_d = wait_q + WT_W'(1);
      S_WR: begin
        if (!last_word)
          idx_d = idx_q + NW_W'(1);
        else if (fill_go)
          idx_d = nwords_q;
      end
      S_FILL: idx_d = idx_q + NW_W'(1);
      default: ;
    endcase
  end

  // next-state sequencing: read, wait out latency, write, repeat per word
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RD;
      S_RD:   state_d = (RD_LAT == 1) ? S_WR : S_WT;
      S_WT:   if (wait_q == WT_W'(RD_LAT - 2)) state_d = S_WR;
      S_WR: begin
        if (!last_word)
          state_d = S_RD;
        else if (fill_go)
          state_d = S_FILL;
        else
          state_d = S_DONE;
      end
      S_FILL: if (last_fill) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RAM strobes and completion pulse, all decoded from the current state
  always_comb begin
    bus.interupt_transfer = 1'b0;
    bus.busy              = (state_q != S_IDLE);
    bus.outer_addr        = '0;
    bus.outer_rd_en       = 1'b0;
    bus.outer_wr_en       = 1'b0;
    bus.outer_wdata       = '0;
    bus.inner_addr        = '0;
    bus.inner_rd_en       = 1'b0;
    bus.inner_wr_en       = 1'b0;
    bus.inner_wdata       = '0;
    case (state_q)
      S_RD: begin
        if (dir_q) begin
          bus.inner_rd_en = 1'b1;
          bus.inner_addr  = inner_src_addr;
        end else begin
          bus.outer_rd_en = 1'b1;
          bus.outer_addr  = outer_src_addr;
        end
      end
      S_WR: begin
        if (dir_q) begin
          bus.outer_wr_en = 1'b1;
          bus.outer_addr  = outer_dst_addr;
          bus.outer_wdata = bus.inner_rdata;
        end else begin
          bus.inner_wr_en = 1'b1;
          bus.inner_addr  = inner_dst_addr;
          bus.inner_wdata = bus.outer_rdata;
        end
      end
      S_FILL: begin
        bus.inner_wr_en = 1'b1;
        bus.inner_addr  = inner_dst_addr;
      end
      S_DONE: bus.interupt_transfer = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_transfer_engine.sv
// tb/tb_ram_transfer_engine.sv - self-checking bench for ram_transfer_engine
`timescale 1ns/1ps
module tb_ram_transfer_engine;

  localparam int WORD_W    = 128;
  localparam int MAX_WORDS = 8;
  localparam int RD_LAT    = 1;

  typedef struct {
    bit                ram;   // 0 outer, 1 inner
    logic [5:0]        addr;
    logic [WORD_W-1:0] data;
  } acc_t;

  typedef struct {
    int         m;
    bit         dir;
    logic [5:0] ra;
    logic [5:0] wa;
    int         nw;
    int         pulse;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ram_transfer_engine_if #(.WORD_W(WORD_W)) bus();

  ram_transfer_engine #(
    .WORD_W(WORD_W), .MAX_WORDS(MAX_WORDS), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [WORD_W-1:0] outer_mem [64];
  logic [WORD_W-1:0] inner_mem [64];
  logic [WORD_W-1:0] ref_outer [64];
  logic [WORD_W-1:0] ref_inner [64];
  logic [WORD_W-1:0] outer_pipe [RD_LAT];
  logic [WORD_W-1:0] inner_pipe [RD_LAT];

  function automatic logic [WORD_W-1:0] rand_word();
    return WORD_W'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  // RAM models: garbage on the read pipe whenever no read was issued
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 64; k++) begin
        outer_mem[k] <= rand_word();
        inner_mem[k] <= rand_word();
      end
    end else begin
      if (bus.outer_wr_en) outer_mem[bus.outer_addr] <= bus.outer_wdata;
      if (bus.inner_wr_en) inner_mem[bus.inner_addr] <= bus.inner_wdata;
    end
    outer_pipe[0] <= bus.outer_rd_en ? outer_mem[bus.outer_addr] : rand_word();
    inner_pipe[0] <= bus.inner_rd_en ? inner_mem[bus.inner_addr] : rand_word();
    for (int k = 1; k < RD_LAT; k++) begin
      outer_pipe[k] <= outer_pipe[k-1];
      inner_pipe[k] <= inner_pipe[k-1];
    end
  end

  assign bus.outer_rdata = outer_pipe[RD_LAT-1];
  assign bus.inner_rdata = inner_pipe[RD_LAT-1];

  logic any_out;
  assign any_out = |{bus.interupt_transfer, bus.busy, bus.outer_addr, bus.outer_rd_en,
                     bus.outer_wr_en, bus.outer_wdata, bus.inner_addr, bus.inner_rd_en,
                     bus.inner_wr_en, bus.inner_wdata};

  task automatic check(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int nwords_of(input int m);
    int n;
    n = (m + WORD_W - 1) / WORD_W;
    if (n < 1) n = 1;
    if (n > MAX_WORDS) n = MAX_WORDS;
    return n;
  endfunction

  function automatic logic [5:0] addr_of(input bit inner, input logic [5:0] base, input int i);
    logic [2:0] off;
    off = 3'(int'(base[2:0]) + i);
    return inner ? {base[5:3], off} : 6'(int'(base) + i);
  endfunction

  task automatic mem_check(input string tag);
    int mo, mi;
    mo = 0;
    mi = 0;
    for (int k = 0; k < 64; k++) begin
      if (outer_mem[k] !== ref_outer[k]) mo++;
      if (inner_mem[k] !== ref_inner[k]) mi++;
    end
    check($sformatf("%s outer_mem_mismatches", tag), mo, 0);
    check($sformatf("%s inner_mem_mismatches", tag), mi, 0);
  endtask

  // mode 0: plain request; 1: request held high through DONE; 2: extra edge while busy
  task automatic run_xfer(input string tag, input int m, input bit dir, input logic [5:0] ra,
                          input logic [5:0] wa, input int nw, input int pulse_nofill, input int mode);
    acc_t rq[$];
    acc_t wq[$];
    logic [5:0] sa, da;
    logic [WORD_W-1:0] d;
    int exp_pulse, cyc, pulse_at, busy_cyc, ri, wi, strobes, post;
    exp_pulse = pulse_nofill;
    for (int i = 0; i < nw; i++) begin
      sa = addr_of(dir, ra, i);
      da = addr_of(!dir, wa, i);
      d  = dir ? ref_inner[sa] : ref_outer[sa];
      rq.push_back('{dir, sa, '0});
      wq.push_back('{!dir, da, d});
      if (dir) ref_outer[da] = d;
      else     ref_inner[da] = d;
    end
`ifdef TRANSFER_ZERO_FILL_EN
    if (!dir) begin
      for (int k = nw; k < MAX_WORDS; k++) begin
        da = addr_of(1'b1, wa, k);
        wq.push_back('{1'b1, da, '0});
        ref_inner[da] = '0;
      end
      exp_pulse += MAX_WORDS - nw;
    end
`endif
    cyc = 0; pulse_at = -1; busy_cyc = 0; ri = 0; wi = 0;
    @(negedge clk);
    bus.Data_len_Polynomial = 10'(m);
    bus.read_write_command  = dir;
    bus.read_address        = ra;
    bus.write_address       = wa;
    bus.command_transfer    = 1'b1;
    while (pulse_at < 0 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      strobes = int'(bus.outer_rd_en) + int'(bus.outer_wr_en) + int'(bus.inner_rd_en) + int'(bus.inner_wr_en);
      check($sformatf("%s strobe_legal c%0d", tag, cyc), strobes > (bus.busy ? 1 : 0), 0);
      if (bus.busy) busy_cyc++;
      if (bus.interupt_transfer) pulse_at = cyc;
      if (bus.outer_rd_en || bus.inner_rd_en) begin
        if (ri < rq.size())
          check($sformatf("%s rd%0d", tag, ri),
                {bus.inner_rd_en, bus.inner_rd_en ? bus.inner_addr : bus.outer_addr},
                {rq[ri].ram, rq[ri].addr});
        else
          check($sformatf("%s extra_read", tag), 1, 0);
        ri++;
      end
      if (bus.outer_wr_en || bus.inner_wr_en) begin
        if (wi < wq.size()) begin
          check($sformatf("%s wr%0d_addr", tag, wi),
                {bus.inner_wr_en, bus.inner_wr_en ? bus.inner_addr : bus.outer_addr},
                {wq[wi].ram, wq[wi].addr});
          check($sformatf("%s wr%0d_data", tag, wi),
                bus.inner_wr_en ? bus.inner_wdata : bus.outer_wdata, wq[wi].data);
        end else
          check($sformatf("%s extra_write", tag), 1, 0);
        wi++;
      end
      if (mode == 0 && cyc == 1) bus.command_transfer = 1'b0;
      if (mode == 2) begin
        if (cyc == 1) bus.command_transfer = 1'b0;
        if (cyc == 2) bus.command_transfer = 1'b1;
        if (cyc == 3) bus.command_transfer = 1'b0;
      end
    end
    check($sformatf("%s pulse_cycle", tag), pulse_at, exp_pulse);
    check($sformatf("%s busy_cycles", tag), busy_cyc, exp_pulse);
    check($sformatf("%s read_count", tag), ri, rq.size());
    check($sformatf("%s write_count", tag), wi, wq.size());
    post = (mode == 1) ? 3 : 1;
    for (int k = 0; k < post; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s post_busy%0d", tag, k), bus.busy, 0);
      check($sformatf("%s post_irq%0d", tag, k), bus.interupt_transfer, 0);
    end
    if (mode == 1) begin
      bus.command_transfer = 1'b0;
      @(posedge clk);
      #1;
    end
    mem_check(tag);
  endtask

  vec_t vecs[9];

  initial begin
    int m, nw;
    bit dir;
    logic [5:0] ra, wa;

    vecs[0] = '{233,  1'b0, 6'h03, 6'h0A, 2, 5};
    vecs[1] = '{571,  1'b1, 6'h1E, 6'h18, 5, 11};
    vecs[2] = '{0,    1'b0, 6'h15, 6'h2B, 1, 3};
    vecs[3] = '{1023, 1'b1, 6'h00, 6'h3C, 8, 17};
    vecs[4] = '{128,  1'b0, 6'h3E, 6'h2D, 1, 3};
    vecs[5] = '{129,  1'b1, 6'h27, 6'h01, 2, 5};
    vecs[6] = '{300,  1'b0, 6'h3F, 6'h07, 3, 7};
    vecs[7] = '{233,  1'b0, 6'h05, 6'h10, 2, 5};
    vecs[8] = '{257,  1'b1, 6'h0C, 6'h3E, 3, 7};

    bus.command_transfer    = 1'b0;
    bus.read_write_command  = 1'b0;
    bus.read_address        = '0;
    bus.write_address       = '0;
    bus.Data_len_Polynomial = '0;
    rst      = 1'b1;
    mem_init = 1'b1;
    @(posedge clk);
    #1;
    mem_init = 1'b0;
    check("reset outputs", any_out, 0);
    for (int k = 0; k < 64; k++) begin
      ref_outer[k] = outer_mem[k];
      ref_inner[k] = inner_mem[k];
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("idle%0d outputs", c), any_out, 0);
    end

    for (int i = 0; i < 9; i++)
      run_xfer($sformatf("vec%0d", i), vecs[i].m, vecs[i].dir, vecs[i].ra, vecs[i].wa,
               vecs[i].nw, vecs[i].pulse, 0);

    run_xfer("reedge", 300, 1'b0, 6'h11, 6'h23, 3, 7, 2);
    run_xfer("hold", 233, 1'b1, 6'h2A, 6'h30, 2, 5, 1);
    run_xfer("after_hold", 129, 1'b0, 6'h08, 6'h3B, 2, 5, 0);

    // reset during the write of word 1 of a 3-word outer->inner copy
    @(negedge clk);
    bus.Data_len_Polynomial = 10'd300;
    bus.read_write_command  = 1'b0;
    bus.read_address        = 6'h20;
    bus.write_address       = 6'h08;
    bus.command_transfer    = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) bus.command_transfer = 1'b0;
    end
    check("rst_mid pre_wr_en", bus.inner_wr_en, 1);
    check("rst_mid pre_addr", bus.inner_addr, 6'h09);
    rst = 1'b1;
    #1;
    check("rst_mid outputs_async", any_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_mid quiet%0d", c), any_out, 0);
    end
    ref_inner[6'h08] = ref_outer[6'h20];
    mem_check("rst_mid");
    run_xfer("after_rst", 300, 1'b0, 6'h20, 6'h08, 3, 7, 0);

    for (int r = 0; r < 20; r++) begin
      m   = int'($urandom_range(0, 1023));
      dir = 1'($urandom_range(0, 1));
      ra  = 6'($urandom);
      wa  = 6'($urandom);
      nw  = nwords_of(m);
      run_xfer($sformatf("rand%0d", r), m, dir, ra, wa, nw, nw * (RD_LAT + 1) + 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
